sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM between the CPU instruction-fetch and data sram-like request channels (req / addr_ok / data_ok).
- Sits between mips_cpu and a unified on-chip RAM, so one memory serves both fetch and load/store.
- Data has priority by default; an anti-starvation counter forces an instruction grant after a bounded wait.
- Routes each one-cycle-latency read response back to the channel that issued it.

Parameters:
MAX_WAIT, 3, consecutive cycles a pending inst request may lose before it wins the next conflict (1..15)
WAIT_W, 4, width of the starvation counter; MAX_WAIT must be < 2^WAIT_W

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
inst_req  in  1  instruction fetch request
inst_addr  in  32  fetch address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch data valid on inst_rdata
inst_rdata  out  32  fetch data
data_req  in  1  data request
data_wr  in  1  1 = write, 0 = read
data_wstrb  in  4  byte enables for writes
data_addr  in  32  data address
data_wdata  in  32  write data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  read data valid / write complete
data_rdata  out  32  read data
ram_en  out  1  SRAM enable
ram_wen  out  4  SRAM byte write enables
ram_addr  out  32  SRAM address
ram_wdata  out  32  SRAM write data
ram_rdata  in  32  SRAM read data, valid one cycle after ram_en

Behaviour:
- Grant logic is combinational; at most one grant per cycle.
  - gnt_d = data_req & ~(inst_req & starve).
  - gnt_i = inst_req & ~gnt_d.
  - starve = (wait_cnt >= MAX_WAIT).
- inst_addr_ok = gnt_i; data_addr_ok = gnt_d. Both are asserted in the same cycle as the request; the requester must hold req/addr/wdata until addr_ok.
- SRAM drive:
  - ram_en = gnt_i | gnt_d.
  - ram_addr = data_addr if gnt_d, else inst_addr.
  - ram_wen = gnt_d & data_wr ? data_wstrb : 4'h0.
  - ram_wdata = data_wdata.
  - When nothing is granted, ram_en = 0, ram_wen = 0 and ram_addr is don't-care.
- wait_cnt (WAIT_W bits):
  - Increments, saturating at MAX_WAIT, when inst_req & ~gnt_i.
  - Clears to 0 when gnt_i or when ~inst_req.
- Response pipeline: registers resp_v <= ram_en and resp_own <= gnt_d (1 = data, 0 = inst).
  - inst_data_ok = resp_v & ~resp_own.
  - data_data_ok = resp_v & resp_own.
  - Latency is exactly 1 cycle after addr_ok.
  - Writes also produce data_data_ok one cycle later.
  - inst_rdata = data_rdata = ram_rdata; only valid when the matching data_ok is high.
- Back-to-back: a new grant is allowed every cycle, including a grant in the same cycle a data_ok is delivered. Throughput is 1 access/cycle.
- No buffering: the requester must sample data when data_ok is high, because a response is never held.
- Simultaneous requests:
  - Data wins unless starve = 1.
  - When starve = 1, inst wins and data_addr_ok = 0 that cycle.
- Reset (async, high):
  - resp_v = 0, resp_own = 0, wait_cnt = 0.
  - Therefore inst_data_ok = data_data_ok = 0 immediately.
  - The combinational outputs follow the req inputs.
  - An in-flight response at reset assertion is dropped, never delivered.

Test Plan:
- Reset high with inst_req = 1 at addr 0xBFC00000 → inst_data_ok = 0 and data_data_ok = 0 during reset. After release: inst_addr_ok = 1, ram_addr = 0xBFC00000, and inst_data_ok = 1 the next cycle with inst_rdata = ram_rdata.
- Continuous inst_req only, addresses incrementing by 4 → inst_addr_ok every cycle and inst_data_ok every cycle from cycle 2; ram_wen = 0 throughout.
- Data write: data_wr = 1, wstrb = 4'b0011, addr 0x80001000, wdata 0x1234ABCD → same cycle ram_wen = 4'b0011 and ram_wdata = 0x1234ABCD; next cycle data_data_ok = 1 and inst_data_ok = 0.
- inst_req and data_req both held high, MAX_WAIT = 3 → grant sequence D, D, D, I, D, D, D, I. wait_cnt = 3 on the inst-grant cycle; data_ok owners follow the same pattern one cycle later.
- Interleave data read at 0x80000010 then inst at 0xBFC00004 on consecutive cycles, with ram_rdata = 0xAAAA0000 then 0x5555FFFF → data_data_ok with 0xAAAA0000, then inst_data_ok with 0x5555FFFF on the following cycle.
- Assert reset the cycle after a data grant → data_data_ok stays 0, and wait_cnt and resp_v read 0 after release.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the instruction-fetch and data channels.
// Data wins conflicts unless the fetch channel has lost MAX_WAIT cycles in a row.
module sram_port_arbiter #(
    parameter int MAX_WAIT = 3,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic              starve;
    logic              gnt_i;
    logic              gnt_d;
    logic              resp_v;
    logic              resp_own;

    assign starve = (wait_cnt >= WAIT_LIMIT);
    assign gnt_d  = data_req & ~(inst_req & starve);
    assign gnt_i  = inst_req & ~gnt_d;

    assign inst_addr_ok = gnt_i;
    assign data_addr_ok = gnt_d;

    assign ram_en    = gnt_i | gnt_d;
    assign ram_addr  = gnt_d ? data_addr : inst_addr;
    assign ram_wen   = (gnt_d & data_wr) ? data_wstrb : 4'h0;
    assign ram_wdata = data_wdata;

    // Counts consecutive cycles a pending fetch was refused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (~inst_req | gnt_i) begin
            wait_cnt <= '0;
        end else if (wait_cnt < WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The SRAM answers one cycle after enable; remember who asked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_v   <= 1'b0;
            resp_own <= 1'b0;
        end else begin
            resp_v   <= ram_en;
            resp_own <= gnt_d;
        end
    end

    assign inst_data_ok = resp_v & ~resp_own;
    assign data_data_ok = resp_v & resp_own;
    assign inst_rdata   = ram_rdata;
    assign data_rdata   = ram_rdata;

endmodule
